// File: rtl/store_buffer_mc.sv
// Multi-chunk AXI write engine: one AW burst per chunk, W beats streamed from SRAM rows,
// per-chunk B tracking with bounded resend of failed chunks.
module store_buffer_mc #(
    parameter int ADDR_W     = 10,
    parameter int SRAM_AW    = 8,
    parameter int SRAM_DW    = 128,
    parameter int WDATA_W    = 64,
    parameter int MAX_CHUNKS = 16,
    parameter int MAX_RETRY  = 3,
    localparam int ID_W      = $clog2(MAX_CHUNKS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_vld,
    output logic                   cmd_rdy,
    input  logic [ADDR_W-1:0]      cmd_awaddr,
    input  logic [7:0]             cmd_awlen,
    input  logic [ID_W-1:0]        cmd_awnum,
    input  logic [SRAM_AW-1:0]     cmd_sram_addr,
    output logic                   lsu_axi_awvld,
    input  logic                   lsu_axi_awrdy,
    output logic [ID_W-1:0]        lsu_axi_awid,
    output logic [ADDR_W-1:0]      lsu_axi_awaddr,
    output logic [7:0]             lsu_axi_awlen,
    output logic [2:0]             lsu_axi_awsize,
    output logic [1:0]             lsu_axi_awburst,
    output logic                   lsu_axi_wvld,
    input  logic                   lsu_axi_wrdy,
    output logic [WDATA_W-1:0]     lsu_axi_wdata,
    output logic [WDATA_W/8-1:0]   lsu_axi_wstrb,
    output logic                   lsu_axi_wlast,
    input  logic                   lsu_axi_bvld,
    input  logic [ID_W-1:0]        lsu_axi_bid,
    input  logic [1:0]             lsu_axi_bresp,
    output logic                   lsu_axi_brdy,
    output logic                   sram_rd_en,
    output logic [SRAM_AW-1:0]     sram_rd_addr,
    input  logic [SRAM_DW-1:0]     sram_rd_data,
    output logic                   done_vld,
    output logic                   done_err,
    output logic                   busy
);

    localparam int BPR     = SRAM_DW / WDATA_W;
    localparam int BPR_LOG = $clog2(BPR);
    localparam int AWSIZE  = $clog2(WDATA_W / 8);
    localparam int RTRY_W  = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_WAIT_B, S_DONE} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]     base_addr_q;
    logic [7:0]            awlen_q;
    logic [ID_W-1:0]       awnum_q;
    logic [SRAM_AW-1:0]    sram_base_q;

    logic [MAX_CHUNKS-1:0] pend_q, resp_q, err_q;
    logic [MAX_CHUNKS-1:0] pend_d, resp_d, err_d;
    logic [RTRY_W-1:0]     retry_q, retry_d;
    logic [MAX_CHUNKS-1:0] live_mask, cmd_mask;

    logic [7:0]            beat_cnt_q;
    logic                  rd_en_q;
    logic [SRAM_AW-1:0]    rd_addr_q;
    logic                  rd_vld_p1, buf_vld_p1;
    logic [SRAM_DW-1:0]    row_p1, row_live;

    logic                  cmd_hs, aw_hs, w_hs, b_hs;
    logic                  retry_go, all_resp, err_any;
    logic                  beat_last, slice_last;
    logic [7:0]            slice;
    logic [ID_W-1:0]       chunk_k;
    logic [8:0]            beats_per_chunk;
    logic [ID_W+8:0]       chunk_beats;
    logic [ADDR_W-1:0]     aw_addr;
    logic [SRAM_AW-1:0]    aw_row;
    logic [WDATA_W-1:0]    wdata_sel;

    function automatic logic [MAX_CHUNKS-1:0] chunk_mask(input logic [ID_W-1:0] last);
        logic [MAX_CHUNKS-1:0] m;
        for (int i = 0; i < MAX_CHUNKS; i++) m[i] = (ID_W'(i) <= last);
        return m;
    endfunction

    assign cmd_rdy       = (state == S_IDLE);
    assign cmd_hs        = cmd_vld & cmd_rdy;
    assign lsu_axi_awvld = (state == S_AW);
    assign aw_hs         = lsu_axi_awvld & lsu_axi_awrdy;
    assign lsu_axi_wvld  = (state == S_W) & (rd_vld_p1 | buf_vld_p1);
    assign w_hs          = lsu_axi_wvld & lsu_axi_wrdy;
    assign lsu_axi_brdy  = (state == S_AW) | (state == S_W) | (state == S_WAIT_B);
    assign b_hs          = lsu_axi_bvld & lsu_axi_brdy & (lsu_axi_bid <= awnum_q);

    assign live_mask = chunk_mask(awnum_q);
    assign cmd_mask  = chunk_mask(cmd_awnum);
    assign all_resp  = ((resp_q & live_mask) == live_mask);
    assign err_any   = |err_q;

    // Next chunk to issue is the lowest pending index.
    always_comb begin
        chunk_k = '0;
        for (int i = MAX_CHUNKS - 1; i >= 0; i--) begin
            if (pend_q[i]) chunk_k = ID_W'(i);
        end
    end

    assign beats_per_chunk = {1'b0, awlen_q} + 9'd1;
    assign chunk_beats     = {{9{1'b0}}, chunk_k} * {{ID_W{1'b0}}, beats_per_chunk};
    assign aw_addr         = base_addr_q + ADDR_W'(32'(chunk_beats) << AWSIZE);
    assign aw_row          = sram_base_q + SRAM_AW'(32'(chunk_beats) >> BPR_LOG);

    assign lsu_axi_awid    = lsu_axi_awvld ? chunk_k : '0;
    assign lsu_axi_awaddr  = lsu_axi_awvld ? aw_addr : '0;
    assign lsu_axi_awlen   = lsu_axi_awvld ? awlen_q : '0;
    assign lsu_axi_awsize  = lsu_axi_awvld ? 3'(AWSIZE) : 3'd0;
    assign lsu_axi_awburst = lsu_axi_awvld ? 2'b01 : 2'b00;

    always_comb begin
        state_nxt = state;
        retry_go  = 1'b0;
        case (state)
            S_IDLE:   if (cmd_hs) state_nxt = S_AW;
            S_AW:     if (aw_hs) state_nxt = S_W;
            S_W:      if (w_hs && beat_last) state_nxt = (pend_q != '0) ? S_AW : S_WAIT_B;
            S_WAIT_B: begin
                if (all_resp) begin
                    if (!err_any || retry_q == RTRY_W'(MAX_RETRY)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_AW;
                        retry_go  = 1'b1;
                    end
                end
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (cmd_hs) begin
            base_addr_q <= cmd_awaddr;
            awlen_q     <= cmd_awlen;
            awnum_q     <= cmd_awnum;
            sram_base_q <= cmd_sram_addr;
        end
    end

    // A resend round re-arms exactly the failed chunks and forgets their old responses.
    always_comb begin
        pend_d  = pend_q;
        resp_d  = resp_q;
        err_d   = err_q;
        retry_d = retry_q;
        if (cmd_hs) begin
            pend_d  = cmd_mask;
            resp_d  = '0;
            err_d   = '0;
            retry_d = '0;
        end else begin
            if (aw_hs) pend_d[chunk_k] = 1'b0;
            if (retry_go) begin
                pend_d  = err_q;
                resp_d  = resp_q & ~err_q;
                err_d   = '0;
                retry_d = retry_q + RTRY_W'(1);
            end
            if (b_hs) begin
                resp_d[lsu_axi_bid] = 1'b1;
                err_d[lsu_axi_bid]  = |lsu_axi_bresp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q  <= '0;
            resp_q  <= '0;
            err_q   <= '0;
            retry_q <= '0;
        end else begin
            pend_q  <= pend_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            retry_q <= retry_d;
        end
    end

    assign slice      = beat_cnt_q & 8'(BPR - 1);
    assign slice_last = (slice == 8'(BPR - 1));
    assign beat_last  = (beat_cnt_q == awlen_q);

    // p0: row read issued; p1: row data returned and buffered while its slices drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_vld_p1  <= 1'b0;
            buf_vld_p1 <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            rd_en_q   <= aw_hs | (w_hs & slice_last & ~beat_last);
            rd_vld_p1 <= rd_en_q;
            if (aw_hs)        rd_addr_q <= aw_row;
            else if (rd_en_q) rd_addr_q <= rd_addr_q + SRAM_AW'(1);
            if (w_hs && slice_last) buf_vld_p1 <= 1'b0;
            else if (rd_vld_p1)     buf_vld_p1 <= 1'b1;
            if (aw_hs)     beat_cnt_q <= '0;
            else if (w_hs) beat_cnt_q <= beat_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_vld_p1) row_p1 <= sram_rd_data;
    end

    assign row_live = rd_vld_p1 ? sram_rd_data : row_p1;

    always_comb begin
        wdata_sel = '0;
        for (int s = 0; s < BPR; s++) begin
            if (slice == 8'(s)) wdata_sel = row_live[s*WDATA_W +: WDATA_W];
        end
    end

    assign lsu_axi_wdata = lsu_axi_wvld ? wdata_sel : '0;
    assign lsu_axi_wstrb = {(WDATA_W/8){lsu_axi_wvld}};
    assign lsu_axi_wlast = lsu_axi_wvld & beat_last;
    assign sram_rd_en    = rd_en_q;
    assign sram_rd_addr  = rd_addr_q;
    assign done_vld      = (state == S_DONE);
    assign done_err      = (state == S_DONE) & err_any;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_store_buffer_mc.sv
// Randomized bench for store_buffer_mc: an SRAM model, random AXI ready/B behaviour and a
// round-based reference of which chunks must be sent, where, and with which data.
module tb_store_buffer_mc;

    localparam int ADDR_W     = 10;
    localparam int SRAM_AW    = 8;
    localparam int SRAM_DW    = 128;
    localparam int WDATA_W    = 64;
    localparam int MAX_CHUNKS = 16;
    localparam int MAX_RETRY  = 3;
    localparam int ID_W       = 4;
    localparam int BPR        = SRAM_DW / WDATA_W;

    logic                 clk, rst_n;
    logic                 cmd_vld, cmd_rdy;
    logic [ADDR_W-1:0]    cmd_awaddr;
    logic [7:0]           cmd_awlen;
    logic [ID_W-1:0]      cmd_awnum;
    logic [SRAM_AW-1:0]   cmd_sram_addr;
    logic                 awvld, awrdy;
    logic [ID_W-1:0]      awid;
    logic [ADDR_W-1:0]    awaddr;
    logic [7:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;
    logic                 wvld, wrdy, wlast;
    logic [WDATA_W-1:0]   wdata;
    logic [WDATA_W/8-1:0] wstrb;
    logic                 bvld, brdy;
    logic [ID_W-1:0]      bid;
    logic [1:0]           bresp;
    logic                 sram_rd_en;
    logic [SRAM_AW-1:0]   sram_rd_addr;
    logic [SRAM_DW-1:0]   sram_rd_data;
    logic                 done_vld, done_err, busy;

    store_buffer_mc #(
        .ADDR_W(ADDR_W), .SRAM_AW(SRAM_AW), .SRAM_DW(SRAM_DW), .WDATA_W(WDATA_W),
        .MAX_CHUNKS(MAX_CHUNKS), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_awaddr(cmd_awaddr), .cmd_awlen(cmd_awlen),
        .cmd_awnum(cmd_awnum), .cmd_sram_addr(cmd_sram_addr),
        .lsu_axi_awvld(awvld), .lsu_axi_awrdy(awrdy), .lsu_axi_awid(awid),
        .lsu_axi_awaddr(awaddr), .lsu_axi_awlen(awlen), .lsu_axi_awsize(awsize),
        .lsu_axi_awburst(awburst),
        .lsu_axi_wvld(wvld), .lsu_axi_wrdy(wrdy), .lsu_axi_wdata(wdata),
        .lsu_axi_wstrb(wstrb), .lsu_axi_wlast(wlast),
        .lsu_axi_bvld(bvld), .lsu_axi_bid(bid), .lsu_axi_bresp(bresp), .lsu_axi_brdy(brdy),
        .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
        .done_vld(done_vld), .done_err(done_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [SRAM_DW-1:0] mem [256];
    int  fail_cnt [MAX_CHUNKS];
    int  attempt  [MAX_CHUNKS];
    int  exp_ids[$];
    int  bq[$];
    bit  exp_err;
    int  cmd_base, cmd_len, cmd_n, cmd_sram;
    int  aw_idx, cur_k, beat_idx, rd_cnt, cyc, aw_cyc;
    bit  w_first_seen, cmd_taken, b_taken, sram_pend, spur_en;
    int  sram_pend_addr;
    int  done_cnt;
    logic done_err_seen;
    int  awrdy_pct, wrdy_pct, bvld_pct;
    logic p_awvld, p_awrdy, p_wvld, p_wrdy, p_wlast;
    logic [ADDR_W-1:0]  p_awaddr;
    logic [ID_W-1:0]    p_awid;
    logic [WDATA_W-1:0] p_wdata;

    task automatic clear_model();
        bq.delete();
        {p_awvld, p_awrdy, p_wvld, p_wrdy, p_wlast} = '0;
        sram_pend    = 1'b0;
        b_taken      = 1'b0;
        cmd_taken    = 1'b0;
        w_first_seen = 1'b1;
        bvld = 1'b0; bid = '0; bresp = '0;
        awrdy = 1'b0; wrdy = 1'b0; cmd_vld = 1'b0;
    endtask

    task automatic check_reset(input string pfx);
        check_val({pfx, "_cmd_rdy"}, cmd_rdy, 1'b1);
        check_val({pfx, "_awvld"}, awvld, 1'b0);
        check_val({pfx, "_awaddr"}, awaddr, '0);
        check_val({pfx, "_awid"}, awid, '0);
        check_val({pfx, "_wvld"}, wvld, 1'b0);
        check_val({pfx, "_wdata"}, wdata, '0);
        check_val({pfx, "_wlast"}, wlast, 1'b0);
        check_val({pfx, "_brdy"}, brdy, 1'b0);
        check_val({pfx, "_rd_en"}, sram_rd_en, 1'b0);
        check_val({pfx, "_rd_addr"}, sram_rd_addr, '0);
        check_val({pfx, "_done"}, {done_vld, done_err}, 2'b00);
        check_val({pfx, "_busy"}, busy, 1'b0);
    endtask

    task automatic do_reset(input string pfx);
        clear_model();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset(pfx);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One clock: observe and score at the falling edge, then drive the next inputs.
    task automatic step();
        int k, row, sl, i;
        logic [SRAM_DW-1:0] r;
        logic [WDATA_W-1:0] e;
        @(negedge clk);
        cyc++;
        if (p_awvld && !p_awrdy) begin
            check_val("aw_hold_vld", awvld, 1'b1);
            check_val("aw_hold_addr", awaddr, p_awaddr);
            check_val("aw_hold_id", awid, p_awid);
        end
        if (p_wvld && !p_wrdy) begin
            check_val("w_hold_vld", wvld, 1'b1);
            check_val("w_hold_data", wdata, p_wdata);
            check_val("w_hold_last", wlast, p_wlast);
        end
        if (cmd_vld && cmd_rdy) cmd_taken = 1'b1;
        if (sram_rd_en) begin
            check_val("rd_addr", sram_rd_addr, (cmd_sram + cur_k * cmd_len / BPR + rd_cnt) % 256);
            rd_cnt++;
            sram_pend      = 1'b1;
            sram_pend_addr = sram_rd_addr;
        end else begin
            sram_pend = 1'b0;
        end
        if (awvld && awrdy) begin
            if (aw_idx < exp_ids.size()) begin
                k = exp_ids[aw_idx];
                check_val("aw_id", awid, k);
                check_val("aw_addr", awaddr, (cmd_base + k * cmd_len * (WDATA_W / 8)) % 1024);
                check_val("aw_len", awlen, cmd_len - 1);
                check_val("aw_size_burst", {awsize, awburst}, {3'd3, 2'b01});
                cur_k = k;
            end else begin
                check_val("aw_count", aw_idx + 1, exp_ids.size());
            end
            aw_idx++;
            beat_idx     = 0;
            rd_cnt       = 0;
            aw_cyc       = cyc;
            w_first_seen = 1'b0;
        end
        if (wvld && !w_first_seen) begin
            check_val("w_latency", cyc - aw_cyc, 2);
            w_first_seen = 1'b1;
        end
        if (wvld && wrdy) begin
            row = (cmd_sram + (cur_k * cmd_len + beat_idx) / BPR) % 256;
            sl  = beat_idx % BPR;
            r   = mem[row];
            e   = r[sl*WDATA_W +: WDATA_W];
            check_val("wdata", wdata, e);
            check_val("wstrb", wstrb, 8'hff);
            check_val("wlast", wlast, beat_idx == cmd_len - 1);
            if (beat_idx == cmd_len - 1) begin
                bq.push_back(cur_k);
                check_val("rd_count", rd_cnt, cmd_len / BPR);
            end
            beat_idx++;
        end
        b_taken = bvld && brdy;
        if (b_taken && int'(bid) < cmd_n) attempt[bid]++;
        if (done_vld) begin
            done_cnt++;
            done_err_seen = done_err;
        end
        p_awvld = awvld; p_awrdy = awrdy; p_awaddr = awaddr; p_awid = awid;
        p_wvld = wvld; p_wrdy = wrdy; p_wdata = wdata; p_wlast = wlast;

        @(posedge clk); #1;
        if (cmd_taken) cmd_vld = 1'b0;
        sram_rd_data = sram_pend ? mem[sram_pend_addr] : {$urandom, $urandom, $urandom, $urandom};
        awrdy = ($urandom_range(99) < awrdy_pct);
        wrdy  = ($urandom_range(99) < wrdy_pct);
        if (b_taken) bvld = 1'b0;
        if (!bvld && bq.size() > 0 && $urandom_range(99) < bvld_pct) begin
            i = $urandom_range(bq.size() - 1);
            k = bq[i];
            bq.delete(i);
            bvld  = 1'b1;
            bid   = ID_W'(k);
            bresp = (attempt[k] < fail_cnt[k]) ? 2'b10 : 2'b00;
        end else if (!bvld && spur_en && busy && bq.size() == 0 && cmd_n < MAX_CHUNKS &&
                     $urandom_range(99) < 5) begin
            bvld  = 1'b1;
            bid   = ID_W'(cmd_n);
            bresp = 2'b10;
        end
    endtask

    task automatic start_cmd(input int base, input int len, input int n, input int sram,
                             input int ar, input int wr, input int br, input bit spur);
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        cmd_base = base; cmd_len = len; cmd_n = n; cmd_sram = sram;
        awrdy_pct = ar; wrdy_pct = wr; bvld_pct = br; spur_en = spur;
        exp_ids.delete();
        exp_err = 1'b0;
        for (int rnd = 0; rnd <= MAX_RETRY; rnd++) begin
            int cnt = 0;
            for (int k = 0; k < n; k++) begin
                if (rnd == 0 || fail_cnt[k] >= rnd) begin
                    exp_ids.push_back(k);
                    cnt++;
                end
            end
            if (cnt == 0) break;
        end
        for (int k = 0; k < n; k++) begin
            attempt[k] = 0;
            if (fail_cnt[k] > MAX_RETRY) exp_err = 1'b1;
        end
        aw_idx = 0; cur_k = 0; beat_idx = 0; rd_cnt = 0; done_cnt = 0;
        done_err_seen = 1'b0; cmd_taken = 1'b0; w_first_seen = 1'b1;
        bq.delete();
        cmd_vld       = 1'b1;
        cmd_awaddr    = ADDR_W'(base);
        cmd_awlen     = 8'(len - 1);
        cmd_awnum     = ID_W'(n - 1);
        cmd_sram_addr = SRAM_AW'(sram);
    endtask

    task automatic run_cmd(input string tag, input int base, input int len, input int n,
                           input int sram, input int ar, input int wr, input int br, input bit spur);
        int budget = 0;
        start_cmd(base, len, n, sram, ar, wr, br, spur);
        while (done_cnt == 0 && budget < 8000) begin
            step();
            budget++;
        end
        if (done_cnt == 0) begin
            check_val({tag, "_timeout"}, 1'b0, 1'b1);
            do_reset({tag, "_recover"});
            return;
        end
        step();
        step();
        bvld = 1'b0;
        check_val({tag, "_done_cnt"}, done_cnt, 1);
        check_val({tag, "_done_err"}, done_err_seen, exp_err);
        check_val({tag, "_aw_total"}, aw_idx, exp_ids.size());
        check_val({tag, "_idle"}, {cmd_rdy, busy}, 2'b10);
    endtask

    task automatic clear_fails();
        for (int k = 0; k < MAX_CHUNKS; k++) fail_cnt[k] = 0;
    endtask

    initial begin
        int budget;
        cyc = 0;
        cmd_awaddr = '0; cmd_awlen = '0; cmd_awnum = '0; cmd_sram_addr = '0;
        sram_rd_data = '0;
        cmd_n = 1; cmd_len = BPR; cmd_sram = 0; cmd_base = 0;
        clear_fails();
        do_reset("reset");

        // single chunk, two rows, all OKAY
        run_cmd("t1", 'h100, 4, 1, 'h10, 100, 100, 100, 1'b0);
        // address wrap across four one-row chunks
        run_cmd("t2", 'h3F0, 2, 4, 'h20, 100, 100, 100, 1'b0);
        // one transient SLVERR, out-of-order B
        clear_fails(); fail_cnt[2] = 1;
        run_cmd("t3", 'h040, 2, 4, 'h30, 80, 80, 40, 1'b0);
        // persistent SLVERR exhausts the resend rounds
        clear_fails(); fail_cnt[1] = 99;
        run_cmd("t4", 'h200, 4, 3, 'hF0, 100, 100, 100, 1'b0);
        // heavy back-pressure on AW and W
        clear_fails();
        run_cmd("t5", 'h080, 8, 3, 'h05, 25, 20, 50, 1'b1);

        // reset while the third beat of a chunk is in flight
        start_cmd('h100, 8, 2, 'h10, 100, 100, 100, 1'b0);
        budget = 0;
        while (beat_idx < 2 && budget < 200) begin
            step();
            budget++;
        end
        check_val("t6_reached_beat2", beat_idx, 2);
        rst_n = 1'b0;
        clear_model();
        @(posedge clk);
        @(negedge clk);
        check_reset("t6");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("t6_quiet", {done_vld, awvld, wvld, sram_rd_en, busy}, 5'b0);
        end
        @(posedge clk); #1;
        run_cmd("t6_after", 'h010, 2, 2, 'h44, 100, 100, 100, 1'b0);

        for (int t = 0; t < 25; t++) begin
            clear_fails();
            for (int k = 0; k < MAX_CHUNKS; k++) begin
                if ($urandom_range(99) < 20) fail_cnt[k] = $urandom_range(1, 4);
            end
            run_cmd("rand", $urandom_range(1023), BPR * $urandom_range(1, 4),
                    $urandom_range(1, MAX_CHUNKS), $urandom_range(255),
                    $urandom_range(30, 100), $urandom_range(30, 100),
                    $urandom_range(20, 100), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
